// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble converter from a 16-bit unsigned sample to 4 BCD digits.
// Optional macro BCD_LEADING_BLANK_EN blanks leading zero digits to 4'hF.
module bin2bcd_converter #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data,
  input  logic        data_valid,
  output logic [15:0] bcd,
  output logic        overflow,
  output logic        bcd_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] sreg;
  logic [19:0] scratch;
  logic [3:0]  cnt;

  logic [19:0] adj;
  logic        ovf;
  logic [15:0] raw;
  logic [15:0] res;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  assign ovf = |scratch[19:16];
  assign raw = (SATURATE && ovf) ? 16'h9999 : scratch[15:0];

`ifdef BCD_LEADING_BLANK_EN
  // Blanking ripples from thousands down; units always shown.
  always_comb begin
    res = raw;
    if (raw[15:12] == 4'h0) begin
      res[15:12] = 4'hF;
      if (raw[11:8] == 4'h0) begin
        res[11:8] = 4'hF;
        if (raw[7:4] == 4'h0)
          res[7:4] = 4'hF;
      end
    end
  end
`else
  assign res = raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_valid) begin
            sreg    <= data;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[18:0], sreg[15]};
          sreg    <= {sreg[14:0], 1'b0};
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd15)
            state <= DONE;
        end
        DONE: begin
          bcd       <= res;
          overflow  <= ovf;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
